// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and helpers for the MIPS multiply/divide unit
// Purpose: operation and FSM state encodings, iteration counter sizing.
// Ports: none (package).
package mips_pkg;

    // Encoding matches the 2-bit op field: bit 1 selects divide, bit 0 selects signed.
    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_t;

    localparam int MDU_M_DEFAULT = 32;
    localparam int MDU_CNT_W     = $clog2(MDU_M_DEFAULT + 1);

    // Iteration counter width for an arbitrary operand width.
    function automatic int mdu_cnt_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO
// Purpose: radix-2 shift-add multiply and restoring divide, one step per cycle,
//          with sign fix-up in a final cycle and MTHI/MTLO write support.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        operation request (sampled in IDLE) and opcode
//   srcA, srcB       multiplicand/dividend, multiplier/divisor
//   wrHi, wrLo       MTHI/MTLO strobes, wrData their data (ignored while busy)
//   busy             operation in progress
//   done             one-cycle pulse when HI/LO receive a result
//   hi, lo           architectural HI/LO registers
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [M-1:0] srcA,
    input  logic [M-1:0] srcB,
    input  logic         wrHi,
    input  logic         wrLo,
    input  logic [M-1:0] wrData,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] hi,
    output logic [M-1:0] lo
);

    localparam int CW = mdu_cnt_width(M);

    mdu_state_t      state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            sign_q;
    logic            sign_r;
    // Multiply: addend (|srcA|). Divide: divisor (|srcB|).
    logic [M-1:0]    opnd;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*M-1:0]  acc;

    // ---------------- operand capture ----------------
    logic          op_signed;
    logic          op_div;
    logic          div_zero;
    logic [M-1:0]  abs_a;
    logic [M-1:0]  abs_b;
    logic          in_sign_a;
    logic          in_sign_b;

    always_comb begin
        op_signed = op[0];
        op_div    = op[1];
        div_zero  = op_div && (srcB == '0);
        // A zero divisor forces the unsigned path: raw dividend, no sign fix-up.
        in_sign_a = op_signed && !div_zero && srcA[M-1];
        in_sign_b = op_signed && !div_zero && srcB[M-1];
        abs_a     = in_sign_a ? (~srcA + 1'b1) : srcA;
        abs_b     = in_sign_b ? (~srcB + 1'b1) : srcB;
    end

    // ---------------- iteration step ----------------
    logic [M:0]      mul_sum;
    logic [2*M-1:0]  mul_next;
    logic [M:0]      div_trial;
    logic [M+1:0]    div_diff;
    logic            div_ok;
    logic [2*M-1:0]  div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*M-1:M]} + (acc[0] ? {1'b0, opnd} : {(M+1){1'b0}});
        mul_next = {mul_sum, acc[M-1:1]};

        // Trial subtraction one bit wider than the trial value so that a zero
        // divisor always succeeds: quotient becomes all ones and the remainder
        // ends up as the untouched dividend.
        div_trial = {acc[2*M-1:M], acc[M-1]};
        div_diff  = {1'b0, div_trial} - {2'b00, opnd};
        div_ok    = !div_diff[M+1];
        div_next  = {(div_ok ? div_diff[M-1:0] : div_trial[M-1:0]), acc[M-2:0], div_ok};
    end

    // ---------------- sign fix-up ----------------
    logic [2*M-1:0] prod_fix;
    logic [M-1:0]   quot_fix;
    logic [M-1:0]   rem_fix;

    always_comb begin
        prod_fix = sign_q ? (~acc + 1'b1) : acc;
        quot_fix = sign_q ? (~acc[M-1:0] + 1'b1) : acc[M-1:0];
        rem_fix  = sign_r ? (~acc[2*M-1:M] + 1'b1) : acc[2*M-1:M];
    end

    // ---------------- FSM, datapath and HI/LO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MDU_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (wrHi) hi <= wrData;
                    if (wrLo) lo <= wrData;
                    if (start) begin
                        state  <= MDU_RUN;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op_div;
                        sign_q <= in_sign_a ^ in_sign_b;
                        sign_r <= in_sign_a;
                        opnd   <= op_div ? abs_b : abs_a;
                        acc    <= {{M{1'b0}}, (op_div ? abs_a : abs_b)};
                    end
                end
                MDU_RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(M - 1)) begin
                        state <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    if (is_div) begin
                        lo <= quot_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[2*M-1:M];
                        lo <= prod_fix[M-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= MDU_IDLE;
                end
                default: begin
                    state <= MDU_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
